// File: rtl/legv8_decoder_reg.sv
// Registered LEGv8 instruction decoder: register-file addresses, extended
// immediate and main datapath controls, one cycle after the instruction.
module legv8_decoder_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  output logic [4:0]  register1,
  output logic [4:0]  register2,
  output logic [4:0]  writeRegister,
  output logic [25:0] immediate,
  output logic        Reg2Loc,
  output logic        Uncondbranch,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemtoReg,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic [1:0]  ALUOp,
  output logic        illegal
);

  typedef enum logic [3:0] {
    K_ILL, K_B, K_BL, K_CB, K_R, K_STUR, K_LDUR, K_ADDI, K_MOV
  } kind_t;

  kind_t       kind;
  logic [4:0]  d_register1, d_register2, d_writeRegister;
  logic [25:0] d_immediate;
  logic        d_Reg2Loc, d_Uncondbranch, d_Branch, d_MemRead, d_MemtoReg;
  logic        d_MemWrite, d_ALUSrc, d_RegWrite, d_illegal;
  logic [1:0]  d_ALUOp;

  // Opcode classes are tried shortest-first; the first match wins.
  always_comb begin
    kind = K_ILL;
    if (instruction[31:26] == 6'b000101)
      kind = K_B;
    else if (instruction[31:26] == 6'b100101)
      kind = K_BL;
    else if (instruction[31:25] == 7'b1011010)
      kind = K_CB;
    else if (instruction[31:23] == 9'b111100101)
      kind = K_MOV;
    else if (instruction[31:22] == 10'b1001000100)
      kind = K_ADDI;
    else begin
      case (instruction[31:21])
        11'b10001010000, 11'b10001011000,
        11'b11001011000, 11'b10101010000: kind = K_R;
        11'b11111000000:                  kind = K_STUR;
        11'b11111000010:                  kind = K_LDUR;
        default:                          kind = K_ILL;
      endcase
    end
  end

  always_comb begin
    d_immediate    = '0;
    d_Reg2Loc      = 1'b0;
    d_Uncondbranch = 1'b0;
    d_Branch       = 1'b0;
    d_MemRead      = 1'b0;
    d_MemtoReg     = 1'b0;
    d_MemWrite     = 1'b0;
    d_ALUSrc       = 1'b0;
    d_RegWrite     = 1'b0;
    d_ALUOp        = 2'b00;
    d_illegal      = 1'b0;
    case (kind)
      K_B: begin
        d_Uncondbranch = 1'b1;
        d_immediate    = instruction[25:0];
      end
      K_BL: begin
        d_Uncondbranch = 1'b1;
        d_RegWrite     = 1'b1;
        d_immediate    = instruction[25:0];
      end
      K_CB: begin
        d_Reg2Loc   = 1'b1;
        d_Branch    = 1'b1;
        d_ALUOp     = 2'b01;
        d_immediate = {{7{instruction[23]}}, instruction[23:5]};
      end
      K_R: begin
        d_RegWrite = 1'b1;
        d_ALUOp    = 2'b10;
      end
      K_STUR: begin
        d_Reg2Loc   = 1'b1;
        d_ALUSrc    = 1'b1;
        d_MemWrite  = 1'b1;
        d_immediate = {{17{instruction[20]}}, instruction[20:12]};
      end
      K_LDUR: begin
        d_ALUSrc    = 1'b1;
        d_MemRead   = 1'b1;
        d_MemtoReg  = 1'b1;
        d_RegWrite  = 1'b1;
        d_immediate = {{17{instruction[20]}}, instruction[20:12]};
      end
      K_ADDI: begin
        d_ALUSrc    = 1'b1;
        d_RegWrite  = 1'b1;
        d_ALUOp     = 2'b10;
        d_immediate = {14'b0, instruction[21:10]};
      end
      K_MOV: begin
        d_ALUSrc    = 1'b1;
        d_RegWrite  = 1'b1;
        d_ALUOp     = 2'b10;
        d_immediate = {10'b0, instruction[20:5]};
      end
      default: d_illegal = 1'b1;
    endcase
  end

  always_comb begin
    d_register1     = instruction[9:5];
    d_register2     = d_Reg2Loc ? instruction[4:0] : instruction[20:16];
    d_writeRegister = (kind == K_BL) ? 5'd30 : instruction[4:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      register1     <= '0;
      register2     <= '0;
      writeRegister <= '0;
      immediate     <= '0;
      Reg2Loc       <= 1'b0;
      Uncondbranch  <= 1'b0;
      Branch        <= 1'b0;
      MemRead       <= 1'b0;
      MemtoReg      <= 1'b0;
      MemWrite      <= 1'b0;
      ALUSrc        <= 1'b0;
      RegWrite      <= 1'b0;
      ALUOp         <= '0;
      illegal       <= 1'b0;
    end else begin
      register1     <= d_register1;
      register2     <= d_register2;
      writeRegister <= d_writeRegister;
      immediate     <= d_immediate;
      Reg2Loc       <= d_Reg2Loc;
      Uncondbranch  <= d_Uncondbranch;
      Branch        <= d_Branch;
      MemRead       <= d_MemRead;
      MemtoReg      <= d_MemtoReg;
      MemWrite      <= d_MemWrite;
      ALUSrc        <= d_ALUSrc;
      RegWrite      <= d_RegWrite;
      ALUOp         <= d_ALUOp;
      illegal       <= d_illegal;
    end
  end

endmodule

// File: tb/tb_legv8_decoder_reg.sv
// Bench for legv8_decoder_reg: directed literal cases plus random instructions
// compared every cycle against an arithmetic decode model.
module tb_legv8_decoder_reg;

  typedef struct packed {
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  wr;
    logic [25:0] imm;
    logic        reg2loc;
    logic        ub;
    logic        br;
    logic        mr;
    logic        m2r;
    logic        mw;
    logic        alusrc;
    logic        rw;
    logic [1:0]  aluop;
    logic        ill;
  } dec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction;
  logic [4:0]  register1, register2, writeRegister;
  logic [25:0] immediate;
  logic        Reg2Loc, Uncondbranch, Branch, MemRead, MemtoReg, MemWrite;
  logic        ALUSrc, RegWrite, illegal;
  logic [1:0]  ALUOp;

  int checks = 0;
  int failures = 0;
  dec_t act, exp_d;

  legv8_decoder_reg dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .register1(register1), .register2(register2), .writeRegister(writeRegister),
    .immediate(immediate), .Reg2Loc(Reg2Loc), .Uncondbranch(Uncondbranch),
    .Branch(Branch), .MemRead(MemRead), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUOp(ALUOp), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign act = {register1, register2, writeRegister, immediate, Reg2Loc,
                Uncondbranch, Branch, MemRead, MemtoReg, MemWrite, ALUSrc,
                RegWrite, ALUOp, illegal};

  function automatic int sext(input int v, input int bits);
    if (v >= (1 << (bits - 1))) return v - (1 << bits);
    return v;
  endfunction

  function automatic dec_t model(input logic [31:0] i);
    dec_t d;
    int unsigned u, op6, op8, op9, op10, op11;
    int v;
    d = '0;
    u = i;
    op6 = u >> 26; op8 = u >> 24; op9 = u >> 23; op10 = u >> 22; op11 = u >> 21;
    v = 0;
    if (op6 == 'h05) begin
      d.ub = 1; v = u % (1 << 26);
    end else if (op6 == 'h25) begin
      d.ub = 1; d.rw = 1; v = u % (1 << 26);
    end else if (op8 == 'hB4 || op8 == 'hB5) begin
      d.reg2loc = 1; d.br = 1; d.aluop = 1;
      v = sext((u >> 5) % (1 << 19), 19);
    end else if (op9 == 'h1E5) begin
      d.alusrc = 1; d.rw = 1; d.aluop = 2; v = (u >> 5) % (1 << 16);
    end else if (op10 == 'h244) begin
      d.alusrc = 1; d.rw = 1; d.aluop = 2; v = (u >> 10) % (1 << 12);
    end else if (op11 == 'h450 || op11 == 'h458 || op11 == 'h658 || op11 == 'h550) begin
      d.rw = 1; d.aluop = 2;
    end else if (op11 == 'h7C0) begin
      d.reg2loc = 1; d.alusrc = 1; d.mw = 1; v = sext((u >> 12) % 512, 9);
    end else if (op11 == 'h7C2) begin
      d.alusrc = 1; d.mr = 1; d.m2r = 1; d.rw = 1; v = sext((u >> 12) % 512, 9);
    end else begin
      d.ill = 1;
    end
    d.imm = v[25:0];
    d.r1 = 5'((u >> 5) % 32);
    d.r2 = d.reg2loc ? 5'(u % 32) : 5'((u >> 16) % 32);
    d.wr = (op6 == 'h25) ? 5'd30 : 5'(u % 32);
    return d;
  endfunction

  // Expected registered outputs: the model of whatever was sampled at the last edge.
  always @(posedge clk) exp_d = rst_n ? model(instruction) : '0;
  always @(negedge rst_n) exp_d = '0;

  always @(negedge clk) begin
    checks++;
    if (act !== exp_d) begin
      failures++;
      $display("FAIL decode t=%0t instr=%h actual=%h required=%h",
               $time, instruction, act, exp_d);
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, a, e);
    end
  endtask

  // Present x and return 1 time unit after the edge that registers it.
  task automatic put(input logic [31:0] x);
    instruction = x;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r, op;
    int sh;
    r = $urandom;
    case ($urandom_range(0, 12))
      0:  begin op = 32'h05;  sh = 26; end
      1:  begin op = 32'h25;  sh = 26; end
      2:  begin op = 32'hB4;  sh = 24; end
      3:  begin op = 32'hB5;  sh = 24; end
      4:  begin op = 32'h1E5; sh = 23; end
      5:  begin op = 32'h244; sh = 22; end
      6:  begin op = 32'h450; sh = 21; end
      7:  begin op = 32'h458; sh = 21; end
      8:  begin op = 32'h658; sh = 21; end
      9:  begin op = 32'h550; sh = 21; end
      10: begin op = 32'h7C0; sh = 21; end
      11: begin op = 32'h7C2; sh = 21; end
      default: return r;
    endcase
    return (r & ((32'd1 << sh) - 32'd1)) | (op << sh);
  endfunction

  initial begin
    rst_n = 1'b1;
    instruction = '0;
    #1 rst_n = 1'b0;
    instruction = 32'h150203E0;
    #1 chk("reset_async", act[31:0], 32'h0);
    chk("reset_async_hi", {12'h0, act[51:32]}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    chk("reset_held", act[31:0], 32'h0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("B_imm", act.imm, 16909280);
    chk("B_ctl", act[10:0], 11'b01000000000);
    #1 put(32'h94202002);
    chk("BL_imm", act.imm, 2105346);
    chk("BL_ctl", act[10:0], 11'b01000001000);
    chk("BL_wr", act.wr, 30);
    #1 put(32'hB42D3945);
    chk("CBZ_imm", act.imm, 92618);
    chk("CBZ_r2", act.r2, 5);
    chk("CBZ_ctl", act[10:0], 11'b10100000010);
    #1 put(32'hB52D3943);
    chk("CBNZ_r2", act.r2, 3);
    chk("CBNZ_ctl", act[10:0], 11'b10100000010);
    #1 put(32'hB4FFFFE0);
    chk("CB_neg_imm", act.imm, 26'h3FFFFFF);
    #1 put(32'h8A040041);
    chk("AND_regs", {17'h0, act.r1, act.r2, act.wr}, {17'h0, 5'd2, 5'd4, 5'd1});
    chk("AND_ctl", act[10:0], 11'b00000001100);
    #1 put(32'hF8048044);
    chk("STUR_regs", {22'h0, act.r1, act.r2}, {22'h0, 5'd2, 5'd4});
    chk("STUR_imm", act.imm, 72);
    chk("STUR_ctl", act[10:0], 11'b10000110000);
    #1 put(32'hF8462060);
    chk("LDUR_regs", {22'h0, act.r1, act.wr}, {22'h0, 5'd3, 5'd0});
    chk("LDUR_imm", act.imm, 98);
    chk("LDUR_ctl", act[10:0], 11'b00011011000);
    // Mid-stream reset must clear the live LDUR decode without an edge.
    #2 rst_n = 1'b0;
    #1 chk("reset_mid", act[31:0], 32'h0);
    chk("reset_mid_hi", {12'h0, act[51:32]}, 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    put(32'h910203E0);
    chk("ADDI_regs", {22'h0, act.r1, act.wr}, {22'h0, 5'd31, 5'd0});
    chk("ADDI_imm", act.imm, 128);
    chk("ADDI_ctl", act[10:0], 11'b00000011100);
    #1 put(32'hF28000E2);
    chk("MOV_wr", act.wr, 2);
    chk("MOV_imm", act.imm, 7);
    chk("MOV_ctl", act[10:0], 11'b00000011100);
    #1 put(32'h00000000);
    chk("ZERO_ctl", act[10:0], 11'b00000000001);
    chk("ZERO_imm", act.imm, 0);
    #1;
    for (int n = 0; n < 3000; n++) begin
      put(rand_instr());
      if (n == 1500) begin
        #1 rst_n = 1'b0;
        #1 chk("reset_rand", act[31:0], 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
      end else begin
        #1;
      end
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/legv8_decoder_reg.md
Name: legv8_decoder_reg

Overview:
- Registered LEGv8 instruction decoder that sits between instruction fetch and the register file / ALU / datapath control.
- Each cycle it samples a 32-bit instruction and produces the register-file addresses, an extended immediate and the main control signals.
- One clock; reset is asynchronous and active-low.

Parameters:
None.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instruction  in  32  instruction word
- register1  out  5  read address 1 (Rn)
- register2  out  5  read address 2
- writeRegister  out  5  destination register
- immediate  out  26  extended immediate
- Reg2Loc  out  1  register2 source select (1 = Rt[4:0], 0 = Rm[20:16])
- Uncondbranch  out  1  unconditional branch
- Branch  out  1  conditional branch
- MemRead  out  1  data memory read
- MemtoReg  out  1  writeback from memory
- MemWrite  out  1  data memory write
- ALUSrc  out  1  ALU operand B = immediate
- RegWrite  out  1  register file write
- ALUOp  out  2  00 = add (address), 01 = pass/compare-zero, 10 = R/I-type operation
- illegal  out  1  opcode not recognised

Behaviour:
- Decode is combinational from instruction; every output is registered on rising clk. Latency is 1 cycle; a new instruction is accepted every cycle.
- While rst_n = 0: all outputs are 0, asynchronously. Reset asserted mid-stream clears outputs immediately. The first edge after release registers the decode of the current instruction.
- Register fields for every opcode:
  - register1 = instr[9:5]
  - register2 = Reg2Loc ? instr[4:0] : instr[20:16]
  - writeRegister = instr[4:0], except BL, which uses 5'd30
- Opcode match order is first match wins: 6-bit, then 8-bit, then 9-bit, then 10-bit, then 11-bit.
- B, [31:26] = 000101: Uncondbranch = 1; immediate = instr[25:0]; all other controls 0.
- BL, [31:26] = 100101: Uncondbranch = 1, RegWrite = 1; writeRegister = 30; immediate = instr[25:0].
- CBZ, [31:24] = 10110100, and CBNZ, 10110101: Reg2Loc = 1, Branch = 1, ALUOp = 01; immediate = sign-extended instr[23:5].
- R-type, [31:21] = 10001010000 AND, 10001011000 ADD, 11001011000 SUB, 10101010000 ORR: RegWrite = 1, ALUOp = 10; immediate = 0.
- STUR, [31:21] = 11111000000: Reg2Loc = 1, ALUSrc = 1, MemWrite = 1, ALUOp = 00; immediate = sign-extended instr[20:12].
- LDUR, [31:21] = 11111000010: ALUSrc = 1, MemRead = 1, MemtoReg = 1, RegWrite = 1, ALUOp = 00; immediate = sign-extended instr[20:12].
- ADDI, [31:22] = 1001000100: ALUSrc = 1, RegWrite = 1, ALUOp = 10; immediate = zero-extended instr[21:10].
- MOV, [31:23] = 111100101: ALUSrc = 1, RegWrite = 1, ALUOp = 10; immediate = zero-extended instr[20:5]. The hw field [22:21] is ignored.
- Any other opcode: all control outputs 0, immediate = 0, illegal = 1. Register fields are still driven per the rules above with Reg2Loc = 0.
- illegal = 0 for every recognised opcode.
- Sign extension replicates the field MSB up to bit 25.

Test Plan:
- Reset: rst_n = 0 with any instruction -> all outputs 0 with no clock edge. Release rst_n; next edge -> decoded outputs appear.
- 32'h150203E0 (B) -> immediate = 16909280, Uncondbranch = 1, all other controls 0. Then 32'h94202002 (BL) -> immediate = 2105346, Uncondbranch = 1, RegWrite = 1, writeRegister = 30.
- 32'hB42D3945 (CBZ X5) -> immediate = 92618, register2 = 5, Reg2Loc = 1, Branch = 1, ALUOp = 01. Then 32'hB52D3943 (CBNZ X3) -> register2 = 3, same controls. Then 19-bit offset 0x7FFFF -> immediate = 26'h3FFFFFF.
- 32'h8A040041 (AND) -> register1 = 2, register2 = 4, writeRegister = 1, RegWrite = 1, ALUOp = 10, Reg2Loc = 0.
- 32'hF8048044 (STUR) -> register1 = 2, register2 = 4, immediate = 72, MemWrite = 1, ALUSrc = 1, Reg2Loc = 1, RegWrite = 0. Then 32'hF8462060 (LDUR) -> register1 = 3, writeRegister = 0, immediate = 98, MemRead = MemtoReg = RegWrite = ALUSrc = 1.
- Back-to-back sequence:
  - 32'h910203E0 (ADDI) -> register1 = 31, writeRegister = 0, immediate = 128, ALUSrc = RegWrite = 1, ALUOp = 10.
  - 32'hF28000E2 (MOV) -> writeRegister = 2, immediate = 7.
  - 32'h00000000 -> illegal = 1, all controls 0.
  - Each result appears exactly one cycle after its instruction is presented.
